// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter_if
// Purpose  : Bundles both requester ports and the data_memory side of the
//            two-port data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  m0_req;
    logic                  m0_we;
    logic [DATA_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wd;
    logic                  m0_ack;
    logic [DATA_WIDTH-1:0] m0_rd;
    logic                  m0_err;

    logic                  m1_req;
    logic                  m1_we;
    logic [DATA_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wd;
    logic                  m1_ack;
    logic [DATA_WIDTH-1:0] m1_rd;
    logic                  m1_err;
    logic                  m1_lock;

    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic                  mem_we;
    logic                  mem_read;
    logic [DATA_WIDTH-1:0] mem_rd;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wd,
        output m0_ack, m0_rd, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wd, m1_lock,
        output m1_ack, m1_rd, m1_err,
        output mem_addr, mem_wd, mem_we, mem_read,
        input  mem_rd
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wd,
        input  m0_ack, m0_rd, m0_err,
        output m1_req, m1_we, m1_addr, m1_wd, m1_lock,
        input  m1_ack, m1_rd, m1_err,
        input  mem_addr, mem_wd, mem_we, mem_read,
        output mem_rd
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Purpose  : Round-robin arbiter/sequencer serialising two masters onto the
//            single-port data_memory, with range check and registered read data.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 65,
    parameter int MAX_LOCK   = 4
) (
    input wire clk,
    input wire reset,
    data_mem_arbiter_if.slave bus
);
    localparam int                    c_LW       = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);
    localparam logic [c_LW-1:0]       c_MAX_LOCK = c_LW'(MAX_LOCK);
    localparam logic [DATA_WIDTH-1:0] c_DEPTH    = DATA_WIDTH'(MEM_DEPTH);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    logic [1:0]            r_state;
    logic                  r_last_owner;
    logic [c_LW-1:0]       r_lock_cnt;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wd;
    logic [DATA_WIDTH-1:0] r_m0_rd;
    logic                  r_m0_err;
    logic [DATA_WIDTH-1:0] r_m1_rd;
    logic                  r_m1_err;

    logic                  w_lock_hold;
    logic                  w_winner;
    logic                  w_in_range;
    logic                  w_access;
    logic [DATA_WIDTH-1:0] w_cap_rd;

    // Lock override only applies while port 1 still owns the last grant.
    always_comb begin
        w_lock_hold = bus.m1_lock && r_last_owner && (r_lock_cnt < c_MAX_LOCK);
        if (bus.m0_req && bus.m1_req) begin
            w_winner = w_lock_hold ? 1'b1 : ~r_last_owner;
        end else begin
            w_winner = bus.m1_req;
        end
    end

    assign w_in_range = (r_addr < c_DEPTH);
    assign w_access   = (r_state == c_ACCESS) && !reset;
    assign w_cap_rd   = (w_in_range && !r_we) ? bus.mem_rd : '0;

    assign bus.mem_we   = w_access && r_we && w_in_range;
    assign bus.mem_read = w_access && !r_we && w_in_range;
    assign bus.mem_addr = (r_state == c_ACCESS) ? r_addr : '0;
    assign bus.mem_wd   = (r_state == c_ACCESS) ? r_wd   : '0;

    assign bus.m0_ack = (r_state == c_RESP) && !r_last_owner;
    assign bus.m1_ack = (r_state == c_RESP) &&  r_last_owner;
    assign bus.m0_rd  = r_m0_rd;
    assign bus.m0_err = r_m0_err;
    assign bus.m1_rd  = r_m1_rd;
    assign bus.m1_err = r_m1_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_last_owner <= 1'b1;
            r_lock_cnt   <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wd         <= '0;
            r_m0_rd      <= '0;
            r_m0_err     <= 1'b0;
            r_m1_rd      <= '0;
            r_m1_err     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.m0_req || bus.m1_req) begin
                        r_last_owner <= w_winner;
                        r_we         <= w_winner ? bus.m1_we   : bus.m0_we;
                        r_addr       <= w_winner ? bus.m1_addr : bus.m0_addr;
                        r_wd         <= w_winner ? bus.m1_wd   : bus.m0_wd;
                        if (!w_winner || !bus.m1_lock) begin
                            r_lock_cnt <= '0;
                        end else if (r_lock_cnt < c_MAX_LOCK) begin
                            r_lock_cnt <= r_lock_cnt + c_LW'(1);
                        end
                        r_state <= c_ACCESS;
                    end
                end
                c_ACCESS: begin
                    if (r_last_owner) begin
                        r_m1_rd  <= w_cap_rd;
                        r_m1_err <= !w_in_range;
                    end else begin
                        r_m0_rd  <= w_cap_rd;
                        r_m0_err <= !w_in_range;
                    end
                    r_state <= c_RESP;
                end
                c_RESP:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Purpose  : Self-checking bench for data_mem_arbiter with a behavioural RAM
//            and an ack-driven scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;
    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          err;
    } vec_t;

    typedef struct {
        bit          port;
        logic [31:0] rd;
        bit          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ram_init;
    logic [31:0] ram [0:64];
    exp_t        sb [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          we_cycles = 0;
    int          rd_cycles = 0;

    data_mem_arbiter_if #(.DATA_WIDTH(32)) bus ();

    data_mem_arbiter #(
        .DATA_WIDTH(32),
        .MEM_DEPTH (65),
        .MAX_LOCK  (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 65; i++) ram[i] <= 32'h1000 + i;
        end else if (bus.mem_we && bus.mem_addr < 32'd65) begin
            ram[bus.mem_addr[6:0]] <= bus.mem_wd;
        end
    end

    assign bus.mem_rd = (bus.mem_addr < 32'd65) ? ram[bus.mem_addr[6:0]] : 32'd0;

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100000");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_we)   we_cycles++;
            if (bus.mem_read) rd_cycles++;
            if (bus.m0_ack || bus.m1_ack) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got m0_ack=%0b m1_ack=%0b, expected none",
                             bus.m0_ack, bus.m1_ack);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", 32'({bus.m1_ack, bus.m0_ack}), e.port ? 32'd2 : 32'd1);
                    chk("ack_rd",  e.port ? bus.m1_rd : bus.m0_rd, e.rd);
                    chk("ack_err", 32'(e.port ? bus.m1_err : bus.m0_err), 32'(e.err));
                end
            end
        end
    endtask

    task automatic drive(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wd);
        if (p) begin
            bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wd = wd;
        end else begin
            bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wd = wd;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        chk({tag, "_acks"}, 32'({bus.m0_ack, bus.m1_ack}), 32'd0);
        chk({tag, "_errs"}, 32'({bus.m0_err, bus.m1_err}), 32'd0);
        chk({tag, "_m0_rd"}, bus.m0_rd, 32'd0);
        chk({tag, "_m1_rd"}, bus.m1_rd, 32'd0);
        chk({tag, "_mem_ctl"}, 32'({bus.mem_we, bus.mem_read}), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction: checks timing, memory strobes, and that the
    // other port's captured result is left alone.
    task automatic txn(input vec_t v);
        exp_t        e;
        int          cyc;
        int          we0;
        int          rd0;
        logic [31:0] oth_rd;
        logic        oth_err;
        bit          inr;
        inr    = (v.addr < 32'd65);
        e.port = v.port; e.rd = v.rd; e.err = v.err;
        sb.push_back(e);
        oth_rd  = v.port ? bus.m0_rd  : bus.m1_rd;
        oth_err = v.port ? bus.m0_err : bus.m1_err;
        we0 = we_cycles;
        rd0 = rd_cycles;
        drive(v.port, v.we, v.addr, v.wd);
        cyc = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) chk("idle_mem_ctl", 32'({bus.mem_we, bus.mem_read}), 32'd0);
            if (i == 1) begin
                chk("acc_mem_ctl", 32'({bus.mem_we, bus.mem_read}),
                    32'({v.we && inr, !v.we && inr}));
                chk("acc_mem_addr", bus.mem_addr, v.addr);
            end
            if (v.port ? bus.m1_ack : bus.m0_ack) begin
                cyc = i;
                break;
            end
        end
        if (v.port) bus.m1_req = 1'b0; else bus.m0_req = 1'b0;
        @(posedge clk);
        #1;
        chk("latency", 32'(cyc), 32'd2);
        chk("we_count", 32'(we_cycles - we0), (v.we && inr) ? 32'd1 : 32'd0);
        chk("rd_count", 32'(rd_cycles - rd0), (!v.we && inr) ? 32'd1 : 32'd0);
        chk("other_rd_hold", v.port ? bus.m0_rd : bus.m1_rd, oth_rd);
        chk("other_err_hold", 32'(v.port ? bus.m0_err : bus.m1_err), 32'(oth_err));
    endtask

    initial begin : main
        vec_t vecs [12];
        bit   exp_seq [13];
        exp_t e;
        int   k;

        vecs[0]  = '{1'b0, 1'b1, 32'd5,          32'd33,        32'd0,         1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'd5,          32'd0,         32'd33,        1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'd64,         32'h0000CAFE,  32'd0,         1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'd65,         32'h0000BEEF,  32'd0,         1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'd64,         32'd0,         32'h0000CAFE,  1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'd65,         32'd0,         32'd0,         1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'd0,         32'd0,         1'b1};
        vecs[7]  = '{1'b1, 1'b0, 32'd5,          32'd0,         32'd33,        1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'd9,          32'h0000DEAD,  32'd0,         1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'd9,          32'd0,         32'h0000DEAD,  1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'd0,          32'd0,         32'h00001000,  1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'd7,          32'd0,         32'h00001007,  1'b0};
        exp_seq  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                     1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wd = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wd = '0;
        bus.m1_lock = 1'b0;
        reset    = 1'b1;
        ram_init = 1'b1;
        fork
            monitor_loop();
        join_none
        @(posedge clk);
        #1;
        ram_init = 1'b0;
        do_reset();
        check_reset_state("reset");

        for (int i = 0; i < 12; i++) txn(vecs[i]);

        // Both ports hold read requests; lock is raised after the sixth grant.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            e.port = exp_seq[i];
            e.rd   = exp_seq[i] ? 32'd33 : 32'h0000DEAD;
            e.err  = 1'b0;
            sb.push_back(e);
        end
        drive(1'b0, 1'b0, 32'd9, 32'd0);
        drive(1'b1, 1'b0, 32'd5, 32'd0);
        k = 0;
        for (int c = 0; c < 60 && k < 13; c++) begin
            @(negedge clk);
            if (bus.m0_ack || bus.m1_ack) begin
                chk("rr_port", 32'(bus.m1_ack), 32'(exp_seq[k]));
                chk("rr_cycle", 32'(c), 32'(2 + 3 * k));
                k++;
                if (k == 6) bus.m1_lock = 1'b1;
            end
        end
        chk("rr_grants", 32'(k), 32'd13);
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        bus.m1_lock = 1'b0;
        @(posedge clk);
        #1;

        // Reset lands during the ACCESS cycle of a write to address 7.
        drive(1'b0, 1'b1, 32'd7, 32'h00000BAD);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.m0_req = 1'b0;
        @(negedge clk);
        chk("rst_access_we", 32'(bus.mem_we), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state("rst_mid");
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ram7", ram[7], 32'h00001007);
        txn('{1'b0, 1'b0, 32'd7, 32'd0, 32'h00001007, 1'b0});

        // Address changes after the IDLE sample must not affect the read.
        e.port = 1'b0; e.rd = 32'd33; e.err = 1'b0;
        sb.push_back(e);
        drive(1'b0, 1'b0, 32'd5, 32'd0);
        @(posedge clk);
        #1;
        bus.m0_addr = 32'd9;
        @(negedge clk);
        chk("late_addr_mem_addr", bus.mem_addr, 32'd5);
        @(negedge clk);
        chk("late_addr_ack", 32'(bus.m0_ack), 32'd1);
        bus.m0_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("late_addr_rd", bus.m0_rd, 32'd33);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
